// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: PC -> four byte reads -> 32-bit little-endian word for ID.
// Optional direct-mapped i-cache enabled by defining ICACHE_EN.
module inst_fetch_unit #(
    parameter int ADDR_LEN     = 32,
    parameter int ICACHE_IDX_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                pc_valid_i,
    input  logic                flush_i,
    output logic                mem_req_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    input  logic                mem_gnt_i,
    input  logic [7:0]          mem_byte_i,
    output logic                inst_valid_o,
    output logic [31:0]         inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o,
    input  logic                id_stall_i,
    output logic                pc_plus4_ready_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_LEN-3:0] base_hi;
    logic [ADDR_LEN-3:0] pc_hi;
    logic [1:0]          k;
    logic [1:0]          pend_k;
    logic                pend;
    logic                take;
    logic                hit;
    logic [31:0]         hit_data;
    logic [1:0]          unused_pc_lo;
    logic [31:0]         unused_idx_w;

    assign pc_hi        = pc_i[ADDR_LEN-1:2];
    assign unused_pc_lo = pc_i[1:0];
    assign unused_idx_w = ICACHE_IDX_W;

    // A new fetch is not started in the pulse cycle, so the PC register
    // has a cycle to present the advanced PC.
    assign take = rst && rdy && (state == IDLE) && pc_valid_i
               && !flush_i && !pc_plus4_ready_o;

    assign mem_req_o  = rst && ((state == FETCH) || (take && !hit));
    assign mem_addr_o = !mem_req_o       ? '0 :
                        (state == FETCH) ? {base_hi, k} :
                                           {pc_hi, 2'b00};

`ifdef ICACHE_EN
    localparam int ENTRIES = 1 << ICACHE_IDX_W;
    localparam int TAG_W   = ADDR_LEN - ICACHE_IDX_W - 2;

    logic [ENTRIES-1:0]      c_valid;
    logic [TAG_W-1:0]        c_tag  [ENTRIES];
    logic [31:0]             c_data [ENTRIES];
    logic [ICACHE_IDX_W-1:0] r_idx;
    logic [ICACHE_IDX_W-1:0] f_idx;
    logic                    fill;

    assign r_idx    = pc_hi[ICACHE_IDX_W-1:0];
    assign f_idx    = base_hi[ICACHE_IDX_W-1:0];
    assign hit      = c_valid[r_idx]
                   && (c_tag[r_idx] == pc_hi[ADDR_LEN-3:ICACHE_IDX_W]);
    assign hit_data = c_data[r_idx];
    assign fill     = rdy && (state == HOLD) && pend
                   && (pend_k == 2'd3) && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_valid <= '0;
        end else if (fill) begin
            c_valid[f_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            c_tag[f_idx]  <= base_hi[ADDR_LEN-3:ICACHE_IDX_W];
            c_data[f_idx] <= {mem_byte_i, inst_o[23:0]};
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            base_hi          <= '0;
            k                <= '0;
            pend_k           <= '0;
            pend             <= 1'b0;
            inst_valid_o     <= 1'b0;
            inst_o           <= '0;
            inst_pc_o        <= '0;
            pc_plus4_ready_o <= 1'b0;
        end else if (rdy) begin
            pc_plus4_ready_o <= 1'b0;
            pend             <= 1'b0;
            if (pend && !flush_i) begin
                inst_o[{pend_k, 3'b000} +: 8] <= mem_byte_i;
            end
            if (flush_i) begin
                state        <= IDLE;
                inst_valid_o <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (take) begin
                            base_hi   <= pc_hi;
                            inst_pc_o <= {pc_hi, 2'b00};
                            if (hit) begin
                                inst_o       <= hit_data;
                                inst_valid_o <= 1'b1;
                                state        <= HOLD;
                            end else begin
                                state  <= FETCH;
                                pend   <= mem_gnt_i;
                                pend_k <= 2'd0;
                                k      <= mem_gnt_i ? 2'd1 : 2'd0;
                            end
                        end
                    end
                    FETCH: begin
                        if (mem_gnt_i) begin
                            pend   <= 1'b1;
                            pend_k <= k;
                            k      <= k + 2'd1;
                            if (k == 2'd3) begin
                                state <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (pend && (pend_k == 2'd3)) begin
                            inst_valid_o <= 1'b1;
                        end else if (inst_valid_o && !id_stall_i) begin
                            inst_valid_o     <= 1'b0;
                            pc_plus4_ready_o <= 1'b1;
                            state            <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: memory responder, transaction-level
// word/cache model, directed scenarios and randomized grant/ready traffic.
module tb_inst_fetch_unit;

    localparam int IW = 6;

    logic        clk        = 1'b0;
    logic        rst        = 1'b0;
    logic        rdy        = 1'b0;
    logic [31:0] pc_i       = '0;
    logic        pc_valid_i = 1'b0;
    logic        flush_i    = 1'b0;
    logic        mem_gnt_i  = 1'b0;
    logic [7:0]  mem_byte_i = '0;
    logic        id_stall_i = 1'b0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        pc_plus4_ready_o;

    inst_fetch_unit #(.ADDR_LEN(32), .ICACHE_IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .pc_i(pc_i), .pc_valid_i(pc_valid_i), .flush_i(flush_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_byte_i(mem_byte_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .id_stall_i(id_stall_i), .pc_plus4_ready_o(pc_plus4_ready_o)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] ctag [int];
    logic [31:0] gq[$];
    logic [31:0] rq[$];
    bit          g_new;
    logic [31:0] g_addr;
    bit          gnt_rand = 0;
    bit          rdy_rand = 0;
    int          gap_left = 0;
    logic [31:0] seen_inst;
    int          seen_lat;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic bit model_hit(input logic [31:0] base);
`ifdef ICACHE_EN
        int idx = int'((base >> 2) & ((32'd1 << IW) - 1));
        return ctag.exists(idx) && (ctag[idx] == base);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_fill(input logic [31:0] base);
`ifdef ICACHE_EN
        ctag[int'((base >> 2) & ((32'd1 << IW) - 1))] = base;
`endif
    endfunction

    // Memory controller model: records requests, returns bytes a cycle after grant.
    always @(posedge clk) begin
        g_new = 1'b0;
        if (rst && rdy && mem_req_o) rq.push_back(mem_addr_o);
        if (rst && rdy && mem_req_o && mem_gnt_i) begin
            gq.push_back(mem_addr_o);
            g_new  = 1'b1;
            g_addr = mem_addr_o;
        end
    end

    always @(negedge clk) begin
        if (g_new) mem_byte_i = mem_rd(g_addr);
        rdy = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (gap_left > 0 && mem_req_o && mem_addr_o[1:0] == 2'd2) begin
            mem_gnt_i = 1'b0;
            gap_left--;
        end else begin
            mem_gnt_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic run_fetch(input logic [31:0] pc, input int stall,
                             input bit chk_lat);
        logic [31:0] base, exp_inst, hold_inst;
        logic [31:0] exp_q[$];
        bit          hit, ok;
        int          c;
        base     = {pc[31:2], 2'b00};
        hit      = model_hit(base);
        exp_inst = {mem_rd(base + 32'd3), mem_rd(base + 32'd2),
                    mem_rd(base + 32'd1), mem_rd(base)};
        if (!hit) exp_q = '{base, base + 32'd1, base + 32'd2, base + 32'd3};
        @(negedge clk);
        gq.delete();
        pc_i       = pc;
        pc_valid_i = 1'b1;
        id_stall_i = (stall > 0);
        c = 0;
        #1;
        if (chk_lat) begin
            checks++;
            if (mem_req_o !== !hit) begin
                errors++;
                $display("FAIL req_cycle0 pc=%h got=%b want=%b", pc, mem_req_o, !hit);
            end
        end
        while (inst_valid_o !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
            #1;
        end
        checks++;
        if (inst_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL fetch_timeout pc=%h", pc);
        end
        seen_inst = inst_o;
        seen_lat  = c;
        if (chk_lat) begin
            checks++;
            if (c != (hit ? 1 : 5)) begin
                errors++;
                $display("FAIL latency pc=%h got=%0d want=%0d", pc, c, hit ? 1 : 5);
            end
        end
        checks++;
        if (inst_o !== exp_inst || inst_pc_o !== base) begin
            errors++;
            $display("FAIL word pc=%h got=%h@%h want=%h@%h",
                     pc, inst_o, inst_pc_o, exp_inst, base);
        end
        ok = (gq.size() == exp_q.size());
        if (ok) foreach (gq[i]) if (gq[i] !== exp_q[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mem_addrs pc=%h got_n=%0d want_n=%0d", pc, gq.size(), exp_q.size());
        end
        hold_inst = inst_o;
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            if (s == stall) id_stall_i = 1'b0;
            #1;
            checks++;
            if (inst_valid_o !== 1'b1 || inst_o !== hold_inst ||
                inst_pc_o !== base || pc_plus4_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold pc=%h got=%b/%h want=1/%h",
                         pc, inst_valid_o, inst_o, hold_inst);
            end
        end
        c = 0;
        do begin
            @(negedge clk);
            #1;
            c++;
        end while (pc_plus4_ready_o !== 1'b1 && c < 50);
        checks++;
        if (pc_plus4_ready_o !== 1'b1 || inst_valid_o !== 1'b0 ||
            (!rdy_rand && c != 1)) begin
            errors++;
            $display("FAIL accept pc=%h got pulse=%b valid=%b after %0d want 1/0 after 1",
                     pc, pc_plus4_ready_o, inst_valid_o, c);
        end
        pc_valid_i = 1'b0;
        if (!rdy_rand) begin
            @(negedge clk);
            #1;
            checks++;
            if (pc_plus4_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL pulse_width pc=%h got=%b want=0", pc, pc_plus4_ready_o);
            end
        end
        model_fill(base);
    endtask

    task automatic flush_at(input logic [31:0] pc, input int n);
        bit ok;
        @(negedge clk);
        pc_i       = pc;
        pc_valid_i = 1'b1;
        id_stall_i = 1'b0;
        repeat (n) @(negedge clk);
        flush_i = 1'b1;
        #1;
        if (n == 0) begin
            checks++;
            if (mem_req_o !== 1'b0) begin
                errors++;
                $display("FAIL flush_idle_req got=%b want=0", mem_req_o);
            end
        end
        @(negedge clk);
        flush_i    = 1'b0;
        pc_valid_i = 1'b0;
        #1;
        checks++;
        if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0 || pc_plus4_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_next n=%0d got req=%b valid=%b pulse=%b want 0/0/0",
                     n, mem_req_o, inst_valid_o, pc_plus4_ready_o);
        end
        ok = 1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (inst_valid_o || pc_plus4_ready_o || mem_req_o) ok = 0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL flush_quiet n=%0d got activity want none", n);
        end
        if (n >= 5) model_fill({pc[31:2], 2'b00});
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, pc_plus4_ready_o} !== '0) begin
            errors++;
            $display("FAIL reset_state got req=%b valid=%b inst=%h want all 0",
                     mem_req_o, inst_valid_o, inst_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        pc_i       = 32'h40;
        pc_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_pc_o, pc_plus4_ready_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_fetch got req=%b addr=%h inst=%h want all 0",
                     mem_req_o, mem_addr_o, inst_o);
        end
        ctag.delete();
        @(negedge clk);
        pc_valid_i = 1'b0;
        rst        = 1'b1;
        run_fetch(32'h0, 0, 1);
    endtask

    task automatic test_miss();
        run_fetch(32'h100, 0, 1);
        checks++;
        if (seen_inst !== 32'h00500013) begin
            errors++;
            $display("FAIL miss_word got=%h want=00500013", seen_inst);
        end
    endtask

    task automatic test_stall();
        run_fetch(32'h104, 3, 1);
    endtask

    task automatic test_gnt_gaps();
        logic [31:0] exp_q[$];
        bit ok;
        exp_q = '{32'h108, 32'h109, 32'h10a, 32'h10a, 32'h10a, 32'h10b};
        rq.delete();
        gap_left = 2;
        run_fetch(32'h108, 0, 0);
        ok = (rq.size() == exp_q.size());
        if (ok) foreach (rq[i]) if (rq[i] !== exp_q[i]) ok = 0;
        checks++;
        if (!ok || seen_lat != 7) begin
            errors++;
            $display("FAIL gnt_gap got n=%0d lat=%0d want n=6 lat=7", rq.size(), seen_lat);
        end
    endtask

    task automatic test_flush();
        flush_at(32'h300, 0);
        flush_at(32'h300, 2);
        run_fetch(32'h200, 0, 1);
        flush_at(32'h504, 4);
        flush_at(32'h608, 5);
        run_fetch(32'h504, 0, 1);
    endtask

    task automatic test_cache();
        run_fetch(32'h100, 0, 1);
        run_fetch(32'h100, 0, 1);
`ifdef ICACHE_EN
        checks++;
        if (seen_lat != 1) begin
            errors++;
            $display("FAIL cache_hit got lat=%0d want 1", seen_lat);
        end
`endif
        run_fetch(32'h100 + 32'd4 * (32'd1 << IW), 0, 1);
        run_fetch(32'h100, 0, 1);
        checks++;
        if (seen_lat != 5) begin
            errors++;
            $display("FAIL cache_alias got lat=%0d want 5", seen_lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        logic [31:0] pc;
        pool = '{32'h100, 32'h104, 32'h200, 32'h1000, 32'hFFFF_FFFC, 32'h0};
        gnt_rand = 1;
        rdy_rand = 1;
        for (int i = 0; i < 40; i++) begin
            pc = (i % 5 == 4) ? $urandom : pool[$urandom_range(0, 5)];
            pc[1:0] = 2'($urandom_range(0, 3));
            run_fetch(pc, $urandom_range(0, 3), 0);
        end
        gnt_rand = 0;
        rdy_rand = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        mem[32'h100] = 8'h13;
        mem[32'h101] = 8'h00;
        mem[32'h102] = 8'h50;
        mem[32'h103] = 8'h00;
        test_reset();
        test_miss();
        test_stall();
        test_gnt_gaps();
        test_flush();
        test_cache();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
